// File: rtl/regfile_sb.sv
// Dual write-back integer register file with a per-register
// pending-write scoreboard and same-cycle write-back bypass.
package regfile_sb_pkg;
    localparam int REG_XLEN = 64;

    typedef struct packed {
        logic                rd_en;
        logic [4:0]          rd;
        logic [REG_XLEN-1:0] res;
    } regpack_t;
endpackage

module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int NREG      = 32,
    parameter int CNT_W     = 2,
    parameter bit ASSERT_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  regpack_t [1:0]        wb_get,
    input  logic [3:0][4:0]       rs_addr,
    output logic [3:0][XLEN-1:0]  rs_data,
    output logic [3:0]            rs_busy,
    input  logic [1:0]            issue_en,
    input  logic [1:0][4:0]       issue_rd,
    output logic [1:0]            sb_full
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [CNT_W-1:0] cnt_q  [NREG];
    logic [CNT_W-1:0] cnt_d  [NREG];
    logic             clamp_err;

    function automatic logic wb_hit(regpack_t p, logic [4:0] a);
        return p.rd_en && (p.rd == a) && (a != 5'd0);
    endfunction

    function automatic logic iss_hit(logic en, logic [4:0] rd,
                                     logic [4:0] a);
        return en && (rd == a) && (a != 5'd0);
    endfunction

    always_comb begin
        logic [4:0] ra;
        int         sum;
        clamp_err = 1'b0;
        ra        = '0;
        sum       = 0;
        regs_d[0] = '0;
        cnt_d[0]  = '0;
        for (int r = 1; r < NREG; r++) begin
            ra        = 5'(r);
            regs_d[r] = regs_q[r];
            // Slot 1 is younger, so its write lands last.
            if (wb_hit(wb_get[0], ra)) regs_d[r] = wb_get[0].res;
            if (wb_hit(wb_get[1], ra)) regs_d[r] = wb_get[1].res;
            sum = int'(cnt_q[r])
                + int'(iss_hit(issue_en[0], issue_rd[0], ra))
                + int'(iss_hit(issue_en[1], issue_rd[1], ra))
                - int'(wb_hit(wb_get[0], ra))
                - int'(wb_hit(wb_get[1], ra));
            if (sum < 0) begin
                cnt_d[r]  = '0;
                clamp_err = 1'b1;
            end else if (sum > int'(CNT_MAX)) begin
                cnt_d[r]  = CNT_MAX;
                clamp_err = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(sum);
            end
        end
    end

    always_comb begin
        logic [4:0] a;
        int         left;
        a    = '0;
        left = 0;
        for (int p = 0; p < 4; p++) begin
            a          = rs_addr[p];
            rs_data[p] = regs_q[a];
            if (wb_hit(wb_get[0], a)) rs_data[p] = wb_get[0].res;
            if (wb_hit(wb_get[1], a)) rs_data[p] = wb_get[1].res;
            if (a == 5'd0) rs_data[p] = '0;
            left = int'(cnt_q[a])
                 - int'(wb_hit(wb_get[0], a))
                 - int'(wb_hit(wb_get[1], a));
            rs_busy[p] = (a != 5'd0) && (left > 0);
        end
        for (int i = 0; i < 2; i++) begin
            sb_full[i] = (issue_rd[i] != 5'd0) &&
                         (cnt_q[issue_rd[i]] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    always @(posedge clk) begin
        if (ASSERT_EN && !rst) begin
            assert (!clamp_err);
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a queue of expected values is filled
// as each step is driven and drained against the settled outputs.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    logic                 clk;
    logic                 rst;
    regpack_t [1:0]       wb_get;
    logic [3:0][4:0]      rs_addr;
    logic [3:0][63:0]     rs_data;
    logic [3:0]           rs_busy;
    logic [1:0]           issue_en;
    logic [1:0][4:0]      issue_rd;
    logic [1:0]           sb_full;

    int vectors     = 0;
    int miscompares = 0;

    string       tag_q[$];
    logic [63:0] val_q[$];

    regfile_sb #(
        .XLEN(64), .NREG(32), .CNT_W(2), .ASSERT_EN(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .wb_get(wb_get),
        .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .issue_en(issue_en), .issue_rd(issue_rd), .sb_full(sb_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        wb_get   = '0;
        issue_en = '0;
        issue_rd = '0;
        rs_addr  = '0;
    endtask

    task automatic wb(int s, logic [4:0] rd, logic [63:0] v);
        wb_get[s].rd_en = 1'b1;
        wb_get[s].rd    = rd;
        wb_get[s].res   = v;
    endtask

    task automatic iss(int s, logic [4:0] rd);
        issue_en[s] = 1'b1;
        issue_rd[s] = rd;
    endtask

    task automatic rd_all(logic [4:0] a);
        rs_addr = {a, a, a, a};
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic exp(string t, logic [63:0] v);
        tag_q.push_back(t);
        val_q.push_back(v);
    endtask

    task automatic chk(logic [63:0] obs);
        string       t;
        logic [63:0] e;
        vectors++;
        if (tag_q.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty observed=%h required=<entry>", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s observed=%h required=%h", t, obs, e);
            end
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        wb(0, 5'd5, 64'hDEAD);
        iss(0, 5'd5);
        tick();
        rst = 1'b0;

        for (int a = 1; a < 32; a++) begin
            rd_all(5'(a));
            issue_rd = {5'(a), 5'(a)};
            exp("rst_data", 64'h0);
            exp("rst_busy", 64'h0);
            exp("rst_full", 64'h0);
            #1;
            chk(rs_data[a % 4]);
            chk(64'(rs_busy[a % 4]));
            chk(64'(sb_full));
        end
        idle();

        wb(0, 5'd0, 64'h1234);
        iss(0, 5'd0);
        rs_addr = {5'd0, 5'd0, 5'd5, 5'd0};
        exp("x0_data", 64'h0);
        exp("x0_busy", 64'h0);
        exp("x0_full", 64'h0);
        exp("x5_kept", 64'h0);
        #1;
        chk(rs_data[0]);
        chk(64'(rs_busy[0]));
        chk(64'(sb_full[0]));
        chk(rs_data[1]);
        tick();
        rd_all(5'd0);
        exp("x0_next", 64'h0);
        exp("x0_nbusy", 64'h0);
        #1;
        chk(rs_data[3]);
        chk(64'(rs_busy[3]));

        wb(0, 5'd7, 64'hAAAA);
        rd_all(5'd7);
        for (int p = 0; p < 4; p++) exp("byp_data", 64'hAAAA);
        exp("byp_busy", 64'h0);
        #1;
        for (int p = 0; p < 4; p++) chk(rs_data[p]);
        chk(64'(rs_busy));
        tick();
        rd_all(5'd7);
        exp("x7_store", 64'hAAAA);
        exp("x7_store3", 64'hAAAA);
        #1;
        chk(rs_data[0]);
        chk(rs_data[3]);

        wb(0, 5'd3, 64'h1);
        wb(1, 5'd3, 64'h2);
        rs_addr = {5'd7, 5'd3, 5'd3, 5'd3};
        exp("dual_byp", 64'h2);
        exp("dual_byp2", 64'h2);
        exp("other_reg", 64'hAAAA);
        #1;
        chk(rs_data[0]);
        chk(rs_data[2]);
        chk(rs_data[3]);
        tick();
        rd_all(5'd3);
        exp("dual_commit", 64'h2);
        #1;
        chk(rs_data[1]);

        iss(0, 5'd9);
        iss(1, 5'd9);
        rd_all(5'd9);
        exp("iss_same_cyc", 64'h0);
        #1;
        chk(64'(rs_busy));
        tick();
        rd_all(5'd9);
        exp("iss_busy", 64'hF);
        #1;
        chk(64'(rs_busy));
        wb(0, 5'd9, 64'h99);
        rd_all(5'd9);
        exp("wb1_busy", 64'hF);
        exp("wb1_data", 64'h99);
        #1;
        chk(64'(rs_busy));
        chk(rs_data[2]);
        tick();
        rd_all(5'd9);
        exp("cnt1_busy", 64'h1);
        #1;
        chk(64'(rs_busy[1]));
        wb(1, 5'd9, 64'h9A);
        rd_all(5'd9);
        exp("wb2_busy", 64'h0);
        exp("wb2_data", 64'h9A);
        #1;
        chk(64'(rs_busy));
        chk(rs_data[0]);
        tick();
        rd_all(5'd9);
        exp("idle_busy", 64'h0);
        exp("idle_data", 64'h9A);
        #1;
        chk(64'(rs_busy));
        chk(rs_data[3]);

        iss(0, 5'd4);
        iss(1, 5'd4);
        exp("sat_full0", 64'h0);
        #1;
        chk(64'(sb_full));
        tick();
        iss(0, 5'd4);
        issue_rd[1] = 5'd4;
        exp("sat_full2", 64'h0);
        #1;
        chk(64'(sb_full));
        tick();
        issue_rd = {5'd4, 5'd4};
        exp("sat_full3", 64'h3);
        #1;
        chk(64'(sb_full));
        iss(0, 5'd4);
        wb(0, 5'd4, 64'h44);
        rd_all(5'd4);
        exp("cancel_full", 64'h1);
        exp("cancel_busy", 64'h1);
        exp("cancel_err", 64'h0);
        #1;
        chk(64'(sb_full[0]));
        chk(64'(rs_busy[0]));
        chk(64'(dut.clamp_err));
        tick();
        issue_rd = {5'd4, 5'd4};
        exp("cancel_hold", 64'h3);
        #1;
        chk(64'(sb_full));
        iss(1, 5'd4);
        exp("clamp_hi_err", 64'h1);
        #1;
        chk(64'(dut.clamp_err));
        tick();
        issue_rd = {5'd4, 5'd4};
        exp("clamp_hi_hold", 64'h3);
        #1;
        chk(64'(sb_full));

        wb(0, 5'd6, 64'h66);
        rd_all(5'd6);
        exp("clamp_lo_err", 64'h1);
        exp("clamp_lo_busy", 64'h0);
        exp("clamp_lo_data", 64'h66);
        #1;
        chk(64'(dut.clamp_err));
        chk(64'(rs_busy));
        chk(rs_data[1]);
        tick();
        iss(0, 5'd6);
        tick();
        rd_all(5'd6);
        issue_rd = {5'd6, 5'd6};
        exp("lo_then_busy", 64'hF);
        exp("lo_then_full", 64'h0);
        #1;
        chk(64'(rs_busy));
        chk(64'(sb_full));

        rst = 1'b1;
        wb(0, 5'd7, 64'hBEEF);
        iss(0, 5'd8);
        tick();
        rst = 1'b0;
        rs_addr  = {5'd8, 5'd6, 5'd7, 5'd4};
        issue_rd = {5'd4, 5'd4};
        exp("mrst_x4busy", 64'h0);
        exp("mrst_x7", 64'h0);
        exp("mrst_x6busy", 64'h0);
        exp("mrst_x8busy", 64'h0);
        exp("mrst_full", 64'h0);
        #1;
        chk(64'(rs_busy[0]));
        chk(rs_data[1]);
        chk(64'(rs_busy[2]));
        chk(64'(rs_busy[3]));
        chk(64'(sb_full));

        if (tag_q.size() != 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_leftover observed=%0d required=0",
                   tag_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running required=done");
        $fatal(1);
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Integer register file and pending-write scoreboard for the dual-issue RV64 core. It consumes the two `regpack_t` write-back packets produced by the WB stage and commits them to 32 × 64-bit architectural registers. It serves four combinational read ports (two per issue slot) with same-cycle write-back bypass. A per-register pending-write counter tells issue which sources are still in flight.

## Interface

Parameters:
- `XLEN`, 64: register width.
- `NREG`, 32: number of architectural registers; x0 is hardwired to zero.
- `CNT_W`, 2: width of each pending-write counter.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `wb_get`  in  `regpack_t [1:0]`: write-back packets (`rd_en`, `rd[4:0]`, `res[XLEN-1:0]`). Slot 1 is younger in program order. `rd_en` is already gated by the WB stall.
- `rs_addr`  in  `[3:0][4:0]`: read addresses. Ports 0/1 are rs1/rs2 of slot 0; ports 2/3 are rs1/rs2 of slot 1.
- `rs_data`  out  `[3:0][XLEN-1:0]`: read data (combinational).
- `rs_busy`  out  `[3:0]`: source still has an outstanding writer that is not resolved this cycle.
- `issue_en`  in  `[1:0]`: instruction in slot i issues this cycle and will write `issue_rd[i]`.
- `issue_rd`  in  `[1:0][4:0]`: destination of each issuing instruction.
- `sb_full`  out  `[1:0]`: the counter of `issue_rd[i]` is at max (3); issue must not assert `issue_en[i]`.

## Operation

- **Storage.** `regs[1..31]` are XLEN-bit flops; `regs[0]` does not exist. Address 0 always reads 0, is never busy, and its writes are dropped.
- **Write commit.** At the posedge, slot j writes `regs[wb_get[j].rd] <= wb_get[j].res` if `rd_en && rd != 0`.
  - Both slots targeting the same rd: slot 1 value is committed.
- **Read**, for each port p with address a:
  - a == 0: 0.
  - Else if slot 1 writes a this cycle: `wb_get[1].res`.
  - Else if slot 0 writes a this cycle: `wb_get[0].res`.
  - Else: `regs[a]`.
- **Counters.** Per register r≠0, `cnt[r]` (CNT_W bits).
  - Next value = `cnt[r]` + (number of issue slots with `issue_en` and `issue_rd == r`) − (number of WB slots with `rd_en` and `rd == r`).
  - The sum is clamped to [0, 3]: an increment at 3 holds 3, and a decrement below 0 holds 0. Clamping is a protocol error, asserted in simulation.
  - Issue and write-back to the same r in one cycle cancel out.
- **Busy.** `rs_busy[p]` = (a≠0) && (`cnt[a]` − same-cycle write-backs to a) > 0.
  - Same-cycle issues do not affect `rs_busy`; intra-bundle RAW is the issue logic's responsibility.
- **Full.** `sb_full[i]` = `cnt[issue_rd[i]] == 3` with `issue_rd[i]` ≠ 0. Combinational, based on the current count.
- **Reset.** All `regs` are cleared to 0 and all `cnt` to 0. As a result:
  - every `rs_data` reads 0 unless bypassed;
  - `rs_busy` = 0;
  - `sb_full` = 0.
- **Reset mid-operation.** Reset overrides any simultaneous write or issue in that cycle. In-flight writers are discarded.

## Timing

- Write-to-read: 0 cycles via bypass; the value is in storage from the next cycle.
- Issue-to-busy: `rs_busy` rises the cycle after `issue_en`.
- Write-back-to-not-busy: `rs_busy` falls in the same cycle as the write-back, while the data is bypassed.
- The `rs_data`, `rs_busy` and `sb_full` paths are purely combinational from their inputs and state. There are no registered outputs.
- No handshake backpressure toward WB: every write-back is accepted every cycle.

## Test plan

- **Reset.** Assert `rst`, then read x1..x31 → all `rs_data` = 0, `rs_busy` = 0. Write x5 = 0xDEAD during the `rst` cycle → x5 still reads 0 afterwards.
- **x0 handling.** WB slot 0 writes x0 = 0x1234 and `issue_en` with rd = x0 → x0 reads 0, `rs_busy` = 0, no counter change.
- **Same-cycle bypass.** Slot 0 writes x7 = 0xAAAA; read x7 on all ports in the same cycle → `rs_data` = 0xAAAA. Next cycle, with no write → still 0xAAAA from storage.
- **Dual-write conflict.** Slot 0 writes x3 = 1 and slot 1 writes x3 = 2 in one cycle → same-cycle read returns 2, and the committed value is 2.
- **Scoreboard lifecycle.**
  - Issue x9 on both slots (cnt 2) → `rs_busy` for x9 is 1 from the next cycle.
  - One write-back → busy stays 1, cnt 1.
  - Second write-back → busy drops in that cycle; the data is bypassed.
- **Saturation and cancel.**
  - Three issues to x4 → `sb_full` = 1.
  - Issue plus write-back to x4 in one cycle → cnt stays 3.
  - A write-back with cnt 0 on x6 → cnt stays 0 and the simulation assertion fires.
